// File: rtl/mem_stage_mq.sv
// mem_stage_mq: memory-access stage with an in-order completion queue.
// Loads retire aligned and extended; responses of flushed entries are dropped.
module mem_stage_mq #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_result,
  input  logic [7:0]       in_op,
  input  logic             in_req,
  input  logic             in_rf_we,
  input  logic [4:0]       in_rf_waddr,
  input  logic             in_exc,
  input  logic             data_ok,
  input  logic [31:0]      rdata,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic             out_rf_we,
  output logic [4:0]       out_rf_waddr,
  output logic [31:0]      out_rf_wdata,
  output logic             out_exc,
  output logic [CNT_W-1:0] occupancy,
  output logic             proto_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] q_valid;
  logic [DEPTH-1:0] q_req;
  logic [DEPTH-1:0] q_done;
  logic [DEPTH-1:0] q_rf_we;
  logic [DEPTH-1:0] q_exc;
  logic [31:0]      q_pc     [DEPTH];
  logic [31:0]      q_result [DEPTH];
  logic [31:0]      q_data   [DEPTH];
  logic [3:0]       q_ld     [DEPTH];
  logic [4:0]       q_waddr  [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] hit_idx;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] pending;
  logic [CNT_W:0]   in_flight;
  logic [DEPTH-1:0] wait_vec;
  logic             hit;
  logic             enq;
  logic             deq;
  logic             rsp_drop;
  logic             rsp_hit;
  logic             rsp_err;
  logic             unused_op;

  logic [31:0] h_res;
  logic [31:0] h_data;
  logic [3:0]  h_ld;
  logic [7:0]  h_byte;
  logic [15:0] h_half;
  logic [31:0] h_wdata;

  // store-width and mem_we bits only matter to the bus side
  assign unused_op = ^{in_op[7], in_op[2:0]};

  assign wait_vec = q_valid & q_req & ~q_done;

  always_comb begin
    pending = '0;
    hit     = 1'b0;
    hit_idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      pending = pending + CNT_W'(wait_vec[i]);
    end
    // walk youngest to oldest so the oldest waiter wins
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (wait_vec[head + PTR_W'(i)]) begin
        hit     = 1'b1;
        hit_idx = head + PTR_W'(i);
      end
    end
  end

  assign in_flight = {1'b0, occ} + {1'b0, drop_cnt};
  assign in_ready  = in_flight < (CNT_W+1)'(DEPTH);
  assign out_valid = q_valid[head] & q_done[head];
  assign occupancy = occ;

  assign enq      = in_valid & in_ready & ~flush;
  assign deq      = out_valid & out_ready & ~flush;
  assign rsp_drop = data_ok & (drop_cnt != '0);
  assign rsp_hit  = data_ok & (drop_cnt == '0) & hit;
  assign rsp_err  = data_ok & (drop_cnt == '0) & ~hit;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q_valid   <= '0;
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      drop_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (rsp_err) begin
        proto_err <= 1'b1;
      end
      if (flush) begin
        q_valid  <= '0;
        head     <= '0;
        tail     <= '0;
        occ      <= '0;
        drop_cnt <= drop_cnt - CNT_W'(rsp_drop)
                  + pending - CNT_W'(rsp_hit);
      end else begin
        if (rsp_drop) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end
        if (enq) begin
          q_valid[tail] <= 1'b1;
          tail          <= tail + PTR_W'(1);
        end
        if (deq) begin
          q_valid[head] <= 1'b0;
          head          <= head + PTR_W'(1);
        end
        occ <= occ + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  // payload needs no reset: every read is qualified by q_valid
  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[tail]     <= in_pc;
      q_result[tail] <= in_result;
      q_ld[tail]     <= in_op[6:3];
      q_req[tail]    <= in_req & ~in_exc;
      q_done[tail]   <= ~in_req | in_exc;
      q_rf_we[tail]  <= in_rf_we;
      q_waddr[tail]  <= in_rf_waddr;
      q_exc[tail]    <= in_exc;
    end
    if (rsp_hit & ~flush) begin
      q_data[hit_idx] <= rdata;
      q_done[hit_idx] <= 1'b1;
    end
  end

  always_comb begin
    h_res  = q_result[head];
    h_data = q_data[head];
    h_ld   = q_ld[head];
    h_byte = 8'(h_data >> {h_res[1:0], 3'b000});
    h_half = h_res[1] ? h_data[31:16] : h_data[15:0];
    unique case (1'b1)
      h_ld[3]: h_wdata = {{24{h_ld[0] & h_byte[7]}}, h_byte};
      h_ld[2]: h_wdata = {{16{h_ld[0] & h_half[15]}}, h_half};
      h_ld[1]: h_wdata = h_data;
      default: h_wdata = h_res;
    endcase
  end

  assign out_pc       = out_valid ? q_pc[head]    : '0;
  assign out_rf_we    = out_valid ? q_rf_we[head] : 1'b0;
  assign out_rf_waddr = out_valid ? q_waddr[head] : '0;
  assign out_rf_wdata = out_valid ? h_wdata       : '0;
  assign out_exc      = out_valid ? q_exc[head]   : 1'b0;

endmodule
